adc_spi_master: RTL

Command-driven SPI master for the AD9648 3-wire serial port. It issues single-byte register writes and reads. Each transaction is a 16-bit instruction (R/W, W1W0=00, 13-bit address) followed by 8 data bits, all MSB first. It sits between the board control logic and two ADC chip selects, and is the initiator end of the ADC serial-port model the team already simulates against. SDIO is split into out, oe and in signals for an external tristate pad.

---
 rtl/adc_spi_pkg.sv | 31 +++
 rtl/spi_halfbit_timer.sv | 37 +++
 rtl/adc_spi_master.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/adc_spi_pkg.sv
// Shared definitions for the AD9648 serial-port master: state encoding,
// frame geometry and the instruction/frame packing helper.
package adc_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  localparam int INSTR_BITS = 16;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = INSTR_BITS + DATA_BITS;
  // Instruction = R/W + W1W0 + address, so the address takes what is left
  localparam int ADDR_BITS  = INSTR_BITS - 3;

  localparam logic [1:0] W1W0_SINGLE = 2'b00;
  localparam logic       RW_READ     = 1'b1;

  // Packs one single-byte transaction, MSB first on the wire
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic                 rw,
    input logic [ADDR_BITS-1:0] addr,
    input logic [DATA_BITS-1:0] wdata
  );
    return {rw, W1W0_SINGLE, addr, wdata};
  endfunction

endpackage

// File: rtl/spi_halfbit_timer.sv
// Half-period timer for SCLK generation: emits a one-cycle tick every
// CLK_DIV system clocks and can be restarted so the first tick of a
// transaction lands exactly CLK_DIV cycles after the command is accepted.
module spi_halfbit_timer
  import adc_spi_pkg::*;
#(
  parameter logic [7:0] CLK_DIV = 8'hFF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick_o = (cnt_q == (CLK_DIV - 8'd1));

  // Next count: wrap on a tick, jump back to zero on restart
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (restart_i || tick_o) begin
      cnt_d = 8'd0;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_spi_master.sv
// Command-driven SPI master for the AD9648 3-wire serial port. Issues one
// 16-bit instruction plus one data byte per command, to either of two chip
// selects. SDIO is split into out/oe/in for an external tristate pad.
module adc_spi_master
  import adc_spi_pkg::*;
#(
  parameter logic [7:0] CLK_DIV = 8'hFF
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_rw,
  input  logic                 cmd_dev,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [DATA_BITS-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 spi_csb1,
  output logic                 spi_csb2,
  output logic                 spi_sclk,
  output logic                 spi_sdio_out,
  output logic                 spi_sdio_oe,
  input  logic                 spi_sdio_in
);

  localparam logic [4:0] TOP_BIT        = 5'(FRAME_BITS - 1);
  localparam logic [4:0] LAST_INSTR_BIT = 5'(DATA_BITS);
  localparam logic [4:0] LAST_DATA_BIT  = 5'(DATA_BITS - 1);

  state_e                 state_q;
  logic [FRAME_BITS-1:0]  frame_q;
  logic                   rw_q;
  logic [4:0]             bit_q;
  logic [DATA_BITS-1:0]   rdata_sr_q;
  logic [DATA_BITS-1:0]   rsp_rdata_q;
  logic                   rsp_valid_q;
  logic                   cmd_ready_q;
  logic                   busy_q;
  logic                   csb1_q;
  logic                   csb2_q;
  logic                   sclk_q;
  logic                   sdio_out_q;
  logic                   sdio_oe_q;

  logic                   accept;
  logic                   tick;

  assign accept = (state_q == IDLE) && cmd_ready_q && cmd_valid;

  spi_halfbit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk_i     (sys_clk),
    .rst_i     (reset),
    .restart_i (accept),
    .tick_o    (tick)
  );

  // Transaction sequencer: every phase advances on a half-period tick and
  // all pad-facing outputs are registered here so they change glitch-free
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      rw_q        <= 1'b0;
      bit_q       <= 5'd0;
      rdata_sr_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      csb1_q      <= 1'b1;
      csb2_q      <= 1'b1;
      sclk_q      <= 1'b0;
      sdio_out_q  <= 1'b0;
      sdio_oe_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          if (accept) begin
            frame_q     <= build_frame(cmd_rw, cmd_addr, cmd_wdata);
            rw_q        <= cmd_rw;
            bit_q       <= TOP_BIT;
            csb1_q      <= cmd_dev;
            csb2_q      <= ~cmd_dev;
            sdio_oe_q   <= 1'b1;
            sdio_out_q  <= cmd_rw;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end

        SETUP: begin
          if (tick) begin
            state_q <= SHIFT;
          end
        end

        SHIFT: begin
          if (tick) begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              if ((rw_q == RW_READ) && (bit_q <= LAST_DATA_BIT)) begin
                rdata_sr_q[bit_q[2:0]] <= spi_sdio_in;
              end
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == 5'd0) begin
                state_q <= HOLD;
              end else begin
                bit_q <= bit_q - 5'd1;
                if ((rw_q == RW_READ) && (bit_q <= LAST_INSTR_BIT)) begin
                  sdio_oe_q  <= 1'b0;
                  sdio_out_q <= 1'b0;
                end else begin
                  sdio_out_q <= frame_q[bit_q - 5'd1];
                end
              end
            end
          end
        end

        HOLD: begin
          if (tick) begin
            csb1_q     <= 1'b1;
            csb2_q     <= 1'b1;
            sdio_oe_q  <= 1'b0;
            sdio_out_q <= 1'b0;
            state_q    <= GAP;
          end
        end

        GAP: begin
          if (tick) begin
            rsp_valid_q <= 1'b1;
            if (rw_q == RW_READ) begin
              rsp_rdata_q <= rdata_sr_q;
            end
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign busy         = busy_q;
  assign spi_csb1     = csb1_q;
  assign spi_csb2     = csb2_q;
  assign spi_sclk     = sclk_q;
  assign spi_sdio_out = sdio_out_q;
  assign spi_sdio_oe  = sdio_oe_q;

endmodule
